// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - FIFO-buffered UART transmitter, 8N1 by default, 8E1 with UART_TX_PARITY_EN
module uart_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int   PW        = $clog2(FIFO_DEPTH);
  localparam int   CW        = PW + 1;
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

  state_t          state;
  state_t          next_state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic [7:0]      shift;
  logic [2:0]      bit_idx;
  logic            stop_cnt;
  logic            stop_final;
  logic            tx_next;
`ifdef UART_TX_PARITY_EN
  logic            parity_bit;
`endif

  assign fifo_empty = (count == '0);
  assign tx_ready   = (count != CW'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign stop_final = (stop_cnt == STOP_LAST);
  assign busy       = (state != ST_IDLE) || !fifo_empty;

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // FIFO pointers and occupancy; a pop only happens when count was already non-zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; every transition waits for a bit-period boundary
  always_comb begin
    next_state = state;
    if (baud_tick) begin
      case (state)
        ST_IDLE:   if (!fifo_empty) next_state = ST_START;
        ST_START:  next_state = ST_DATA;
`ifdef UART_TX_PARITY_EN
        ST_DATA:   if (bit_idx == 3'd7) next_state = ST_PARITY;
        ST_PARITY: next_state = ST_STOP;
`else
        ST_DATA:   if (bit_idx == 3'd7) next_state = ST_STOP;
`endif
        ST_STOP:   if (stop_final) next_state = fifo_empty ? ST_IDLE : ST_START;
        default:   next_state = ST_IDLE;
      endcase
    end
  end

  // Output decode: next line level and FIFO pop at each frame start
  always_comb begin
    pop     = 1'b0;
    tx_next = tx;
    if (baud_tick) begin
      case (state)
        ST_IDLE: begin
          tx_next = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            tx_next = 1'b0;
          end
        end
        ST_START: tx_next = shift[0];
        ST_DATA: begin
          if (bit_idx != 3'd7) tx_next = shift[1];
`ifdef UART_TX_PARITY_EN
          else                 tx_next = parity_bit;
`else
          else                 tx_next = 1'b1;
`endif
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: tx_next = 1'b1;
`endif
        ST_STOP: begin
          if (stop_final && !fifo_empty) begin
            pop     = 1'b1;
            tx_next = 1'b0;
          end
        end
        default: tx_next = 1'b1;
      endcase
    end
  end

  // Datapath: registered line, shift register, bit index and stop-bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx       <= 1'b1;
      shift    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      tx <= tx_next;
      if (pop)                                shift <= mem[rd_ptr];
      else if (baud_tick && state == ST_DATA) shift <= {1'b0, shift[7:1]};
      if (baud_tick) begin
        bit_idx  <= (state == ST_DATA) ? bit_idx + 3'd1 : 3'd0;
        stop_cnt <= (state == ST_STOP && !stop_final) ? stop_cnt + 1'b1 : 1'b0;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  // Even parity is captured at load time, since the shift register is consumed bit by bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   parity_bit <= 1'b0;
    else if (pop) parity_bit <= ^mem[rd_ptr];
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized self-checking bench for uart_tx against a bit-queue line model
module tb_uart_tx;

  logic       clk;
  logic       rst_n;
  logic       tick0, tick1;
  logic [7:0] data0, data1;
  logic       valid0, valid1;
  logic       rdy0, rdy1;
  logic       tx0, tx1;
  logic       busy0, busy1;

  uart_tx #(.FIFO_DEPTH(4), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .baud_tick(tick0), .tx_data(data0),
    .tx_valid(valid0), .tx_ready(rdy0), .tx(tx0), .busy(busy0)
  );

  uart_tx #(.FIFO_DEPTH(8), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(tick1), .tx_data(data1),
    .tx_valid(valid1), .tx_ready(rdy1), .tx(tx1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int errors;

  // Line model: bytes waiting in the FIFO, bits of the frame on the wire
  logic [7:0] pend[$];
  logic       cur_bits[$];
  logic       exp_tx;
  logic       in_frame;
  int         depth;
  int         nstop;
  int         sel;
  logic [2:0] obs;

  task automatic set_sel(input int s);
    sel   = s;
    depth = (s == 0) ? 4 : 8;
    nstop = (s == 0) ? 1 : 2;
    pend.delete();
    cur_bits.delete();
    exp_tx   = 1'b1;
    in_frame = 1'b0;
  endtask

  task automatic model_tick();
    logic [7:0] b;
    if (cur_bits.size() == 0 && pend.size() != 0) begin
      b = pend.pop_front();
      cur_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) cur_bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
      cur_bits.push_back(^b);
`endif
      for (int i = 0; i < nstop; i++) cur_bits.push_back(1'b1);
    end
    if (cur_bits.size() != 0) begin
      exp_tx   = cur_bits.pop_front();
      in_frame = 1'b1;
    end else begin
      exp_tx   = 1'b1;
      in_frame = 1'b0;
    end
  endtask

  function automatic logic [2:0] expv();
    return {exp_tx, (in_frame || pend.size() != 0), (pend.size() < depth)};
  endfunction

  function automatic logic model_idle();
    return pend.size() == 0 && cur_bits.size() == 0 && !in_frame;
  endfunction

  // One clock: drive at the falling edge, update the model at the rising edge, observe at the next falling edge
  task automatic cycle(input logic tk, input logic vld, input logic [7:0] d, output logic acc);
    tick0  = (sel == 0) && tk;
    tick1  = (sel == 1) && tk;
    valid0 = (sel == 0) && vld;
    valid1 = (sel == 1) && vld;
    data0  = d;
    data1  = d;
    acc    = vld && (pend.size() < depth);
    @(posedge clk);
    if (tk)  model_tick();
    if (acc) pend.push_back(d);
    @(negedge clk);
    obs = (sel == 0) ? {tx0, busy0, rdy0} : {tx1, busy1, rdy1};
  endtask

  task automatic test_reset();
    logic [2:0] got;
    got = {tx0, busy0, rdy0};
    vectors++;
    if (got !== 3'b101) begin errors++; $display("FAIL reset_dut0 tx/busy/rdy got %b want 101", got); end
    got = {tx1, busy1, rdy1};
    vectors++;
    if (got !== 3'b101) begin errors++; $display("FAIL reset_dut1 tx/busy/rdy got %b want 101", got); end
    rst_n = 1'b1;
    @(negedge clk);
    got = {tx0, busy0, rdy0};
    vectors++;
    if (got !== 3'b101) begin errors++; $display("FAIL reset_release tx/busy/rdy got %b want 101", got); end
  endtask

  task automatic test_basic();
    logic acc;
    set_sel(0);
    cycle(1'b0, 1'b1, 8'h55, acc);
    vectors++;
    if (obs !== expv()) begin errors++; $display("FAIL basic_push got %b want %b", obs, expv()); end
    for (int p = 0; p < 12; p++) begin
      for (int c = 0; c < 16; c++) begin
        cycle(c == 0, 1'b0, 8'h00, acc);
        vectors++;
        if (obs !== expv()) begin
          errors++; $display("FAIL basic_0x55 t=%0t tx/busy/rdy got %b want %b", $time, obs, expv());
        end
      end
    end
    vectors++;
    if (obs[1] !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b want 0", obs[1]); end
  endtask

  task automatic test_back_to_back();
    logic acc;
    logic [7:0] bytes [3];
    bytes = '{8'hA3, 8'h00, 8'hFF};
    set_sel(0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, bytes[i], acc);
      vectors++;
      if (obs !== expv()) begin errors++; $display("FAIL b2b_push%0d got %b want %b", i, obs, expv()); end
    end
    for (int n = 0; n < 1000 && !model_idle(); n++) begin
      cycle((n % 5) == 0, 1'b0, 8'h00, acc);
      vectors++;
      if (obs !== expv()) begin
        errors++; $display("FAIL b2b_frames t=%0t tx/busy/rdy got %b want %b", $time, obs, expv());
      end
    end
  endtask

  task automatic test_fifo_full();
    logic acc;
    logic held;
    set_sel(0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 8'h10 + 8'(i), acc);
      vectors++;
      if (obs !== expv()) begin errors++; $display("FAIL full_push%0d got %b want %b", i, obs, expv()); end
    end
    vectors++;
    if (obs[0] !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", obs[0]); end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 8'h5A, acc);
      vectors++;
      if (obs !== expv()) begin errors++; $display("FAIL full_hold got %b want %b", obs, expv()); end
    end
    held = 1'b1;
    for (int n = 0; n < 1500 && (held || !model_idle()); n++) begin
      cycle((n % 4) == 0, held, 8'h5A, acc);
      if (acc) held = 1'b0;
      vectors++;
      if (obs !== expv()) begin
        errors++; $display("FAIL full_drain t=%0t tx/busy/rdy got %b want %b", $time, obs, expv());
      end
    end
  endtask

  task automatic test_parity();
    logic acc;
    set_sel(0);
    cycle(1'b0, 1'b1, 8'h07, acc);
    cycle(1'b0, 1'b1, 8'h03, acc);
    for (int n = 0; n < 500 && !model_idle(); n++) begin
      cycle((n % 3) == 0, 1'b0, 8'h00, acc);
      vectors++;
      if (obs !== expv()) begin
        errors++; $display("FAIL parity_frames t=%0t tx/busy/rdy got %b want %b", $time, obs, expv());
      end
    end
  endtask

  task automatic test_stop2();
    logic acc;
    set_sel(1);
    cycle(1'b0, 1'b1, 8'h81, acc);
    cycle(1'b0, 1'b1, 8'h18, acc);
    vectors++;
    if (obs !== expv()) begin errors++; $display("FAIL stop2_push got %b want %b", obs, expv()); end
    for (int n = 0; n < 600 && !model_idle(); n++) begin
      cycle((n % 6) == 0, 1'b0, 8'h00, acc);
      vectors++;
      if (obs !== expv()) begin
        errors++; $display("FAIL stop2_frames t=%0t tx/busy/rdy got %b want %b", $time, obs, expv());
      end
    end
  endtask

  task automatic test_random();
    logic       acc;
    logic       vld;
    logic       tk;
    logic [7:0] d;
    int         tcnt;
    for (int s = 0; s < 2; s++) begin
      set_sel(s);
      vld  = 1'b0;
      d    = 8'h00;
      tcnt = 0;
      for (int n = 0; n < 1500; n++) begin
        if (tcnt == 0) begin tk = 1'b1; tcnt = $urandom_range(2, 5); end
        else begin tk = 1'b0; tcnt--; end
        if (!vld) begin
          vld = ($urandom_range(0, 2) == 0);
          d   = 8'($urandom);
        end
        cycle(tk, vld, d, acc);
        if (acc) vld = 1'b0;
        vectors++;
        if (obs !== expv()) begin
          errors++; $display("FAIL random_dut%0d t=%0t tx/busy/rdy got %b want %b", s, $time, obs, expv());
        end
      end
      for (int n = 0; n < 2000 && !model_idle(); n++) begin
        cycle((n % 4) == 0, 1'b0, 8'h00, acc);
        vectors++;
        if (obs !== expv()) begin
          errors++; $display("FAIL random_drain%0d t=%0t got %b want %b", s, $time, obs, expv());
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic       acc;
    logic [2:0] got;
    set_sel(0);
    cycle(1'b0, 1'b1, 8'h3C, acc);
    cycle(1'b0, 1'b1, 8'h11, acc);
    cycle(1'b0, 1'b1, 8'h22, acc);
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 4; c++) begin
        cycle(c == 0, 1'b0, 8'h00, acc);
        vectors++;
        if (obs !== expv()) begin errors++; $display("FAIL rstmid_pre got %b want %b", obs, expv()); end
      end
    end
    #2 rst_n = 1'b0;
    #1 got = {tx0, busy0, rdy0};
    vectors++;
    if (got !== 3'b101) begin errors++; $display("FAIL rstmid_async tx/busy/rdy got %b want 101", got); end
    @(negedge clk);
    rst_n = 1'b1;
    set_sel(0);
    for (int p = 0; p < 15; p++) begin
      for (int c = 0; c < 4; c++) begin
        cycle(c == 0, 1'b0, 8'h00, acc);
        vectors++;
        if (obs !== expv()) begin errors++; $display("FAIL rstmid_after got %b want %b", obs, expv()); end
      end
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst_n   = 1'b0;
    tick0   = 1'b0;
    tick1   = 1'b0;
    valid0  = 1'b0;
    valid1  = 1'b0;
    data0   = 8'h00;
    data1   = 8'h00;
    set_sel(0);
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_fifo_full();
    test_parity();
    test_stop2();
    test_random();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
